// File: rtl/multicycle_control_unit.sv
// Multi-cycle LEGv8 controller: sequences fetch/decode/execute over a shared ALU,
// a unified memory port and a register bank. Traps on unsupported opcodes.
module multicycle_control_unit #(
  parameter int COUNT_WIDTH        = 32,
  parameter bit FETCH_INCREMENT_EN = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [10:0]            opcode,
  input  logic                   mem_ready,
  input  logic                   zero,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   pc_source,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_to_loc,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic [3:0]             state,
  output logic                   trap,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_LD = 4'd5,
    S_MEM_ST = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_LD  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_LD  = 2'd1,
    CLS_ST  = 2'd2,
    CLS_CBZ = 2'd3
  } class_t;

  state_t                 r_state;
  class_t                 r_class;
  logic                   r_reg_to_loc;
  logic [COUNT_WIDTH-1:0] r_retired;

  logic   w_is_r;
  logic   w_is_ld;
  logic   w_is_st;
  logic   w_is_cbz;
  logic   w_legal;
  logic   w_reg_to_loc;
  class_t w_class;

  // The ALU zero flag is combined with pc_write_cond in the datapath, not here.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  assign w_is_r   = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                    (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign w_is_ld  = (opcode == 11'b11111000010);
  assign w_is_st  = (opcode == 11'b11111000000);
  assign w_is_cbz = (opcode[10:3] == 8'b10110100);
  assign w_legal  = w_is_r || w_is_ld || w_is_st || w_is_cbz;
  assign w_reg_to_loc = w_is_st || w_is_cbz;

  always_comb begin
    w_class = CLS_R;
    if (w_is_ld)       w_class = CLS_LD;
    else if (w_is_st)  w_class = CLS_ST;
    else if (w_is_cbz) w_class = CLS_CBZ;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_class      <= CLS_R;
      r_reg_to_loc <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (enable) r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_class      <= w_class;
          r_reg_to_loc <= w_reg_to_loc;
          if (!w_legal)                                r_state <= S_TRAP;
          else if (w_class == CLS_R)                   r_state <= S_EXEC_R;
          else if (w_class == CLS_CBZ)                 r_state <= S_BRANCH;
          else                                         r_state <= S_ADDR;
        end
        S_EXEC_R: r_state <= S_WB_R;
        S_ADDR:   r_state <= (r_class == CLS_LD) ? S_MEM_LD : S_MEM_ST;
        S_MEM_LD: if (mem_ready) r_state <= S_WB_LD;
        S_MEM_ST: begin
          if (mem_ready) begin
            r_retired <= r_retired + COUNT_WIDTH'(1);
            r_state   <= S_FETCH;
          end
        end
        S_WB_R, S_WB_LD, S_BRANCH: begin
          r_retired <= r_retired + COUNT_WIDTH'(1);
          r_state   <= S_FETCH;
        end
        S_TRAP:   r_state <= S_TRAP;
        // Unreachable encodings are treated as a fault.
        default:  r_state <= S_TRAP;
      endcase
    end
  end

  // Moore decode from the state register; only FETCH looks at mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_to_loc    = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    trap          = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready & FETCH_INCREMENT_EN;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        reg_to_loc = w_reg_to_loc;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        reg_to_loc = r_reg_to_loc;
      end
      S_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        reg_to_loc = r_reg_to_loc;
      end
      S_MEM_LD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        reg_to_loc = r_reg_to_loc;
      end
      S_MEM_ST: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        reg_to_loc = r_reg_to_loc;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_to_loc = r_reg_to_loc;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_to_loc = r_reg_to_loc;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        reg_to_loc    = r_reg_to_loc;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized program bench for multicycle_control_unit: a memory responder feeds
// opcodes and wait states, a monitor scores each retired instruction against a model.
module tb_multicycle_control_unit;
  localparam int CW = 32;
  localparam int N  = 40;

  logic          clock = 1'b0;
  logic          reset, enable, mem_ready, zero;
  logic [10:0]   opcode;
  logic          pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic          ir_write, reg_to_loc, reg_write, mem_to_reg, alu_src_a, trap;
  logic [1:0]    alu_src_b, alu_op;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  multicycle_control_unit #(.COUNT_WIDTH(CW), .FETCH_INCREMENT_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .opcode(opcode),
    .mem_ready(mem_ready), .zero(zero), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_to_loc(reg_to_loc), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .trap(trap), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cls;   // 0 R, 1 LDUR, 2 STUR, 3 CBZ
    int wf;    // fetch wait cycles
    int wd;    // data wait cycles
  } rec_t;

  int          vectors = 0;
  int          miscompares = 0;
  rec_t        sb_q[$];
  int          wait_q[$];
  logic [10:0] op_q[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: expected per-instruction totals derived from the instruction rules.
  function automatic longint model(input rec_t r, input int k);
    bit is_r, is_ld, is_st, is_cbz;
    is_r = (r.cls == 0); is_ld = (r.cls == 1); is_st = (r.cls == 2); is_cbz = (r.cls == 3);
    case (k)
      0:  return r.wf + 1 + (is_ld ? r.wd + 1 : 0);
      1:  return is_st ? r.wd + 1 : 0;
      2:  return (is_ld || is_st) ? r.wd + 1 : 0;
      3:  return 1;
      4:  return 1;
      5:  return (is_r || is_ld) ? 1 : 0;
      6:  return is_ld ? 1 : 0;
      7:  return is_cbz ? 1 : 0;
      8:  return is_cbz ? 1 : 0;
      9:  return is_st ? 3 + r.wd : (is_cbz ? 2 : 0);
      10: return 1;
      11: return is_r ? 1 : 0;
      12: return is_cbz ? 1 : 0;
      13: return r.wf + 1;
      14: return 1;
      15: return (is_ld || is_st) ? 1 : 0;
      16: return is_r ? 4 + r.wf : is_ld ? 5 + r.wf + r.wd : is_st ? 4 + r.wf + r.wd : 3 + r.wf;
      17: return is_r ? 'h1237 : is_ld ? 'h12458 : is_st ? 'h1246 : 'h129;
      default: return 0;
    endcase
  endfunction

  function automatic string cnt_name(input int k);
    case (k)
      0: return "mem_read_cycles";    1: return "mem_write_cycles";
      2: return "i_or_d_cycles";      3: return "ir_write_cycles";
      4: return "pc_write_cycles";    5: return "reg_write_cycles";
      6: return "mem_to_reg_cycles";  7: return "pc_write_cond_cycles";
      8: return "pc_source_cycles";   9: return "reg_to_loc_cycles";
      10: return "alu_src_a_cycles";  11: return "alu_op_rtype_cycles";
      12: return "alu_op_passb_cycles"; 13: return "alu_src_b_four_cycles";
      14: return "alu_src_b_shl2_cycles"; 15: return "alu_src_b_sext_cycles";
      16: return "instr_cycles";      17: return "state_path";
      default: return "unknown";
    endcase
  endfunction

  // Memory responder: each access pops a wait count; completed fetches deliver the next opcode.
  int rem = -1;
  bit done_last = 1'b0;
  bit fetch_last = 1'b0;
  always @(negedge clock) begin
    zero = 1'($urandom_range(0, 1));
    if (reset) begin
      rem = -1; done_last = 1'b0; fetch_last = 1'b0; mem_ready = 1'b0;
    end else begin
      if (done_last) begin
        rem = -1;
        done_last = 1'b0;
        if (fetch_last && op_q.size() > 0) opcode = op_q.pop_front();
        fetch_last = 1'b0;
      end
      if (mem_read || mem_write) begin
        if (rem < 0) rem = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        if (rem == 0) begin
          mem_ready = 1'b1; done_last = 1'b1; fetch_last = !i_or_d;
        end else begin
          mem_ready = 1'b0; rem--;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: accumulate per-instruction activity, score when retired advances.
  int         cnt [18];
  logic [3:0] prev_state = 4'd0;
  logic [CW-1:0] last_ret = '0;
  int         n_retired = 0;
  always @(negedge clock) begin
    #2;
    if (reset || !mon_en) begin
      foreach (cnt[k]) cnt[k] = 0;
      last_ret = retired; prev_state = state;
    end else begin
      if (retired !== last_ret) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 64'd1, 64'd0);
        end else begin
          rec_t r;
          r = sb_q.pop_front();
          n_retired++;
          for (int k = 0; k < 18; k++) check(cnt_name(k), 64'(cnt[k]), 64'(model(r, k)));
          check("retired", 64'(retired), 64'(n_retired));
        end
        foreach (cnt[k]) cnt[k] = 0;
        last_ret = retired;
      end
      if (state != 4'd0) begin
        cnt[0] += int'(mem_read);   cnt[1] += int'(mem_write);
        cnt[2] += int'(i_or_d);     cnt[3] += int'(ir_write);
        cnt[4] += int'(pc_write);   cnt[5] += int'(reg_write);
        cnt[6] += int'(mem_to_reg); cnt[7] += int'(pc_write_cond);
        cnt[8] += int'(pc_source);  cnt[9] += int'(reg_to_loc);
        cnt[10] += int'(alu_src_a);
        cnt[11] += int'(alu_op == 2'b10);    cnt[12] += int'(alu_op == 2'b01);
        cnt[13] += int'(alu_src_b == 2'b01); cnt[14] += int'(alu_src_b == 2'b11);
        cnt[15] += int'(alu_src_b == 2'b10);
        cnt[16] += 1;
        if (state != prev_state) cnt[17] = (cnt[17] << 4) | int'(state);
      end
      prev_state = state;
      check("rd_wr_exclusive", 64'(mem_read & mem_write), 64'd0);
      check("regwr_memwr_exclusive", 64'(reg_write & mem_write), 64'd0);
    end
  end

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clock); #2; n++;
    end
    check(name, 64'(state), 64'(s));
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    reset = 1'b1; enable = 1'b0;
    wait_q.delete(); op_q.delete();
    @(negedge clock); #2;
    reset = 1'b0;
  endtask

  function automatic logic [10:0] pick_opcode(input int cls);
    int sel;
    sel = $urandom_range(0, 3);
    case (cls)
      0: case (sel)
           0: return 11'b10001011000;
           1: return 11'b11001011000;
           2: return 11'b10001010000;
           default: return 11'b10101010000;
         endcase
      1: return 11'b11111000010;
      2: return 11'b11111000000;
      default: return {8'b10110100, 3'($urandom_range(0, 7))};
    endcase
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; opcode = 11'd0; mem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    check("reset_state", 64'(state), 64'd0);
    check("reset_retired", 64'(retired), 64'd0);
    check("reset_trap", 64'(trap), 64'd0);
    check("reset_outputs", 64'({pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
          ir_write, reg_to_loc, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op}), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    check("idle_without_enable", 64'(state), 64'd0);

    // Random program with random wait states; enable drops early and must not stop it.
    for (int i = 0; i < N; i++) begin
      rec_t r;
      r.cls = $urandom_range(0, 3);
      r.wf  = $urandom_range(0, 3);
      r.wd  = (r.cls == 1 || r.cls == 2) ? $urandom_range(0, 3) : 0;
      op_q.push_back(pick_opcode(r.cls));
      wait_q.push_back(r.wf);
      if (r.cls == 1 || r.cls == 2) wait_q.push_back(r.wd);
      sb_q.push_back(r);
    end
    mon_en = 1'b1;
    enable = 1'b1;
    begin
      int n = 0;
      while (retired != CW'(N) && n < 4000) begin
        @(negedge clock); #2; n++;
        if (n == 6) enable = 1'b0;
      end
    end
    check("program_done", 64'(retired), 64'(N));
    repeat (2) @(negedge clock);
    #2;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    mon_en = 1'b0;

    // Illegal opcode traps and holds regardless of enable.
    do_reset();
    op_q.push_back(11'b11111111111);
    wait_q.push_back(0);
    enable = 1'b1;
    wait_state(4'd15, 20, "enter_trap");
    for (int i = 0; i < 20; i++) begin
      enable = 1'($urandom_range(0, 1));
      @(negedge clock); #2;
      check("trap_state", 64'(state), 64'd15);
      check("trap_flag", 64'(trap), 64'd1);
      check("trap_strobes", 64'({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}), 64'd0);
    end
    do_reset();
    check("trap_cleared_state", 64'(state), 64'd0);
    check("trap_cleared_flag", 64'(trap), 64'd0);

    // Reset mid-store aborts without retiring.
    op_q.push_back(11'b11111000000);
    wait_q.push_back(0);
    wait_q.push_back(50);
    enable = 1'b1;
    wait_state(4'd6, 20, "reach_mem_st");
    repeat (2) @(negedge clock);
    #2;
    check("store_waiting_mem_write", 64'(mem_write), 64'd1);
    check("store_waiting_reg_to_loc", 64'(reg_to_loc), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_mem_write", 64'(mem_write), 64'd0);
    check("abort_state", 64'(state), 64'd0);
    check("abort_retired", 64'(retired), 64'd0);
    @(negedge clock); #2;
    reset = 1'b0;
    wait_q.delete(); op_q.delete();
    enable = 1'b1;
    wait_state(4'd1, 5, "resume_fetch");
    check("resume_retired", 64'(retired), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
